// File: rtl/jmps.sv
// jmps: conditional jump-on-sign next-PC selector.
// On each exec strobe the next program counter is chosen and registered.
// If the sign flag is set, the GPR jump target is used. Otherwise the
// sequential successor of pc is used. new_pc and taken hold between strobes.
// new_pc_valid marks the single cycle that follows each strobe.
module jmps #(
    parameter int PC_WIDTH = 20,
    parameter int PC_STEP  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                exec,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                sign_flag,
    input  logic [PC_WIDTH-1:0] jmp_address,
    output logic [PC_WIDTH-1:0] new_pc,
    output logic                taken,
    output logic                new_pc_valid
);

    logic [PC_WIDTH-1:0] new_pc_q;
    logic [PC_WIDTH-1:0] new_pc_d;
    logic                taken_q;
    logic                taken_d;
    logic                new_pc_valid_q;
    logic                new_pc_valid_d;
    logic [PC_WIDTH-1:0] seq_pc;

    // Sequential successor wraps naturally at PC_WIDTH bits; carry is dropped
    assign seq_pc = pc + PC_WIDTH'(PC_STEP);

    // Next-state selection: inputs matter only on an exec cycle, otherwise hold
    always_comb begin
        new_pc_d       = new_pc_q;
        taken_d        = taken_q;
        new_pc_valid_d = 1'b0;
        if (exec) begin
            new_pc_valid_d = 1'b1;
            if (sign_flag) begin
                new_pc_d = jmp_address;
                taken_d  = 1'b1;
            end else begin
                new_pc_d = seq_pc;
                taken_d  = 1'b0;
            end
        end
    end

    // Result registers; synchronous reset takes priority over a same-cycle exec
    always_ff @(posedge clk) begin
        if (rst) begin
            new_pc_q       <= '0;
            taken_q        <= 1'b0;
            new_pc_valid_q <= 1'b0;
        end else begin
            new_pc_q       <= new_pc_d;
            taken_q        <= taken_d;
            new_pc_valid_q <= new_pc_valid_d;
        end
    end

    assign new_pc       = new_pc_q;
    assign taken        = taken_q;
    assign new_pc_valid = new_pc_valid_q;

endmodule

// File: tb/tb_jmps.sv
// Directed testbench for jmps.
// Each feature task drives its vectors and compares against hand-computed values.
module tb_jmps;

    logic        clk;
    logic        rst;
    logic        exec;
    logic [19:0] pc;
    logic        sign_flag;
    logic [19:0] jmp_address;
    logic [19:0] new_pc;
    logic        taken;
    logic        new_pc_valid;

    int total;
    int bad;

    jmps #(
        .PC_WIDTH(20),
        .PC_STEP (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .exec        (exec),
        .pc          (pc),
        .sign_flag   (sign_flag),
        .jmp_address (jmp_address),
        .new_pc      (new_pc),
        .taken       (taken),
        .new_pc_valid(new_pc_valid)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change on the falling edge, away from the sampling edge
    task automatic drive(input logic r, input logic e, input logic s,
                         input logic [19:0] p, input logic [19:0] a);
        @(negedge clk);
        rst         = r;
        exec        = e;
        sign_flag   = s;
        pc          = p;
        jmp_address = a;
    endtask

    // Advance past the next rising edge so registered outputs have settled
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 20'h00000, 20'hABCDE);
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (new_pc !== 20'h00000) begin
                bad++;
                $display("[TB] FAIL reset_new_pc cycle %0d: got %h expected 00000", i, new_pc);
            end
            total++;
            if (taken !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_taken cycle %0d: got %b expected 0", i, taken);
            end
            total++;
            if (new_pc_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_valid cycle %0d: got %b expected 0", i, new_pc_valid);
            end
        end
    endtask

    task automatic test_not_taken();
        drive(1'b0, 1'b1, 1'b0, 20'h00000, 20'hABCDE);
        step();
        total++;
        if (new_pc !== 20'h00001) begin
            bad++;
            $display("[TB] FAIL not_taken_new_pc: got %h expected 00001", new_pc);
        end
        total++;
        if (taken !== 1'b0) begin
            bad++;
            $display("[TB] FAIL not_taken_taken: got %b expected 0", taken);
        end
        total++;
        if (new_pc_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL not_taken_valid: got %b expected 1", new_pc_valid);
        end
        drive(1'b0, 1'b0, 1'b1, 20'h00500, 20'h11111);
        step();
        total++;
        if (new_pc_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL not_taken_valid_pulse: got %b expected 0", new_pc_valid);
        end
        total++;
        if (new_pc !== 20'h00001) begin
            bad++;
            $display("[TB] FAIL not_taken_hold: got %h expected 00001", new_pc);
        end
    endtask

    task automatic test_taken();
        logic s;
        drive(1'b0, 1'b1, 1'b1, 20'h00000, 20'hABCDE);
        step();
        total++;
        if (new_pc !== 20'hABCDE) begin
            bad++;
            $display("[TB] FAIL taken_new_pc: got %h expected abcde", new_pc);
        end
        total++;
        if (taken !== 1'b1) begin
            bad++;
            $display("[TB] FAIL taken_taken: got %b expected 1", taken);
        end
        total++;
        if (new_pc_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL taken_valid: got %b expected 1", new_pc_valid);
        end
        s = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, s, 20'h00100 + 20'(i), 20'h54321);
            s = ~s;
            step();
            total++;
            if (new_pc !== 20'hABCDE || taken !== 1'b1 || new_pc_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL taken_hold cycle %0d: got pc=%h taken=%b valid=%b expected pc=abcde taken=1 valid=0",
                         i, new_pc, taken, new_pc_valid);
            end
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b1, 1'b0, 20'hFFFFF, 20'h12345);
        step();
        total++;
        if (new_pc !== 20'h00000) begin
            bad++;
            $display("[TB] FAIL wrap_new_pc: got %h expected 00000", new_pc);
        end
        total++;
        if (taken !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wrap_taken: got %b expected 0", taken);
        end
    endtask

    task automatic test_back_to_back();
        logic        s_vec [3];
        logic [19:0] p_vec [3];
        logic [19:0] a_vec [3];
        logic [19:0] exp_pc [3];
        logic        exp_tk [3];
        s_vec[0] = 1'b1; p_vec[0] = 20'h00010; a_vec[0] = 20'h12345; exp_pc[0] = 20'h12345; exp_tk[0] = 1'b1;
        s_vec[1] = 1'b0; p_vec[1] = 20'h00020; a_vec[1] = 20'h77777; exp_pc[1] = 20'h00021; exp_tk[1] = 1'b0;
        s_vec[2] = 1'b1; p_vec[2] = 20'h00030; a_vec[2] = 20'h00000; exp_pc[2] = 20'h00000; exp_tk[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, s_vec[i], p_vec[i], a_vec[i]);
            step();
            total++;
            if (new_pc !== exp_pc[i] || taken !== exp_tk[i] || new_pc_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL back_to_back step %0d: got pc=%h taken=%b valid=%b expected pc=%h taken=%b valid=1",
                         i, new_pc, taken, new_pc_valid, exp_pc[i], exp_tk[i]);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 20'h00000, 20'h00000);
        step();
        total++;
        if (new_pc_valid !== 1'b0 || new_pc !== 20'h00000 || taken !== 1'b1) begin
            bad++;
            $display("[TB] FAIL back_to_back_end: got pc=%h taken=%b valid=%b expected pc=00000 taken=1 valid=0",
                     new_pc, taken, new_pc_valid);
        end
    endtask

    task automatic test_reset_priority();
        drive(1'b0, 1'b1, 1'b1, 20'h00040, 20'hABCDE);
        step();
        total++;
        if (new_pc !== 20'hABCDE || taken !== 1'b1) begin
            bad++;
            $display("[TB] FAIL prio_setup: got pc=%h taken=%b expected pc=abcde taken=1", new_pc, taken);
        end
        drive(1'b1, 1'b1, 1'b1, 20'h00040, 20'hABCDE);
        step();
        total++;
        if (new_pc !== 20'h00000 || taken !== 1'b0 || new_pc_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL prio_reset: got pc=%h taken=%b valid=%b expected pc=00000 taken=0 valid=0",
                     new_pc, taken, new_pc_valid);
        end
        // First exec after reset release must be processed normally, here with jmp_address == pc
        drive(1'b0, 1'b1, 1'b1, 20'h00777, 20'h00777);
        step();
        total++;
        if (new_pc !== 20'h00777 || taken !== 1'b1 || new_pc_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL post_reset_exec: got pc=%h taken=%b valid=%b expected pc=00777 taken=1 valid=1",
                     new_pc, taken, new_pc_valid);
        end
    endtask

    // Scenario sequence
    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        exec        = 1'b0;
        sign_flag   = 1'b0;
        pc          = '0;
        jmp_address = '0;
        $display("[TB] starting jmps tests");
        test_reset();
        test_not_taken();
        test_taken();
        test_wrap();
        test_back_to_back();
        test_reset_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
